mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (IF) and a
// data requester (DM). Data accesses win by default. A fairness counter lets
// at most FAIR_LIMIT consecutive data grants through while a fetch is waiting.
// After that the fetch gets the port. Every transaction is guarded by a wait
// counter. When it expires, the owner gets a zero-data completion and the
// sticky bus_err flag is set.
//
// Parameters
//   TIMEOUT_CYC  wait cycles allowed for mem_ack before a bus error
//   FAIR_LIMIT   consecutive data grants allowed while if_req is pending
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until if_ready)
//   if_rdata/if_ready             fetched word (registered), one-cycle done pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_type              data request (held until dm_ready)
//   dm_rdata/dm_ready             load data (registered), one-cycle done pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_type            shared memory port, registered and held per txn
//   mem_ack/mem_rdata             memory completion and read data
//   bus_err                       sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int FAIR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,

  output logic        bus_err
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int FAIR_W = (FAIR_LIMIT  > 1) ? $clog2(FAIR_LIMIT + 1)  : 1;

  // The last wait cycle ends in a timeout instead of another increment.
  // This holds mem_req high for exactly TIMEOUT_CYC cycles.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX  = FAIR_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [FAIR_W-1:0] fair_cnt;

  logic dm_eligible;
  logic if_eligible;
  logic dm_grant;
  logic if_grant;

  // While a requester's ready pulse is high, its req line still shows the
  // request that just finished. It must not be granted again in that cycle.
  assign dm_eligible = dm_req && !dm_ready;
  assign if_eligible = if_req && !if_ready;

  // Data has priority until the fairness budget is used up.
  //
  // The fetch side looks at the raw dm_req on purpose. When a data
  // requester keeps dm_req high back-to-back, its completion cycle becomes
  // an idle gap rather than handing the port to the fetch early. Only the
  // fairness counter passes the port to the fetch.
  //
  // The !if_req term only matters when the counter is saturated and no
  // fetch is waiting. It keeps the data side from stalling in that case.
  assign dm_grant = dm_eligible && ((fair_cnt < FAIR_MAX) || !if_req);
  assign if_grant = if_eligible && (!dm_req || (fair_cnt == FAIR_MAX));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  // The data-holding registers (rdata, address, wdata) are reset too, because
  // their values are visible on the ports from the first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      fair_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= 3'b000;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      // The fairness counter only tracks data grants made while a fetch waits.
      if (!if_req) begin
        fair_cnt <= '0;
      end else if (state == IDLE && if_grant) begin
        fair_cnt <= '0;
      end else if (state == IDLE && dm_grant && fair_cnt < FAIR_MAX) begin
        fair_cnt <= fair_cnt + FAIR_W'(1);
      end

      case (state)
        IDLE: begin
          // mem_ack is deliberately ignored here.
          if (dm_grant) begin
            state     <= DM_WAIT;
            wait_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_type  <= dm_type;
          end else if (if_grant) begin
            state    <= IF_WAIT;
            wait_cnt <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_type <= 3'b000;
          end
        end

        IF_WAIT, DM_WAIT: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == IF_WAIT) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_ready <= 1'b1;
              // A store leaves the last load result in place.
              if (!mem_we) dm_rdata <= mem_rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Timeout: complete with zero data so the requester is not stuck.
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (state == IF_WAIT) begin
              if_ready <= 1'b1;
              if_rdata <= '0;
            end else begin
              dm_ready <= 1'b1;
              dm_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (TIMEOUT_CYC=8, FAIR_LIMIT=4).
// Each request pushes its expected owner and read data onto a scoreboard
// queue. Each ready pulse pops the oldest entry and compares against it.
// Inputs change 1 ns after the rising edge, and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_if;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_type;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  mem_port_arbiter #(
    .TIMEOUT_CYC(8),
    .FAIR_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_type  (dm_type),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_type (mem_type),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for mem_req, then check the presented command.
  task automatic await_mem(input logic [31:0] addr, input logic we,
                           input logic [2:0] typ, input logic [31:0] wdata,
                           input string tag);
    int k = 0;
    while (!mem_req && k < 40) begin
      cyc();
      k++;
    end
    check1({tag, " mem_req"}, mem_req, 1'b1);
    check({tag, " mem_addr"}, mem_addr, addr);
    check1({tag, " mem_we"}, mem_we, we);
    check({tag, " mem_type"}, 32'(mem_type), 32'(typ));
    if (we) check({tag, " mem_wdata"}, mem_wdata, wdata);
  endtask

  // Hold the port for 'delay' cycles while checking it stays stable, then ack.
  task automatic hold_ack(input int delay, input logic [31:0] rd,
                          input logic [31:0] addr, input logic we,
                          input logic [2:0] typ, input logic [31:0] wdata,
                          input string tag);
    for (int i = 0; i < delay; i++) begin
      cyc();
      check1({tag, " hold mem_req"}, mem_req, 1'b1);
      check({tag, " hold mem_addr"}, mem_addr, addr);
      if (we) begin
        check({tag, " hold mem_wdata"}, mem_wdata, wdata);
        check({tag, " hold mem_type"}, 32'(mem_type), 32'(typ));
      end
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    check1({tag, " mem_req after ack"}, mem_req, 1'b0);
  endtask

  // Wait (bounded) for a ready pulse and compare it with the oldest expectation.
  task automatic get_ready(input bit drop, input string tag);
    int   k = 0;
    exp_t e;
    while (!(if_ready || dm_ready) && k < 40) begin
      cyc();
      k++;
    end
    if (!(if_ready || dm_ready)) begin
      check1({tag, " ready seen"}, 1'b0, 1'b1);
      return;
    end
    if (sb.size() == 0) begin
      check1({tag, " ready expected"}, 1'b1, 1'b0);
      cyc();
      return;
    end
    e = sb.pop_front();
    check1({tag, " owner is_if"}, if_ready, e.is_if);
    check1({tag, " single ready"}, if_ready & dm_ready, 1'b0);
    if (e.is_if) check({tag, " if_rdata"}, if_rdata, e.rdata);
    else         check({tag, " dm_rdata"}, dm_rdata, e.rdata);
    if (drop) begin
      if (e.is_if) if_req = 1'b0;
      else         dm_req = 1'b0;
    end
    cyc();
    check1({tag, " one-cycle pulse"}, if_ready | dm_ready, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    dm_type   = 3'b000;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // ---- reset state ----
    cyc();
    check1("rst mem_req", mem_req, 1'b0);
    check1("rst mem_we", mem_we, 1'b0);
    check1("rst if_ready", if_ready, 1'b0);
    check1("rst dm_ready", dm_ready, 1'b0);
    check1("rst bus_err", bus_err, 1'b0);
    check("rst if_rdata", if_rdata, 32'h0);
    check("rst dm_rdata", dm_rdata, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst mem_type", 32'(mem_type), 32'h0);
    cyc();
    rst = 1'b1;
    cyc();

    // ---- fetch only, one-cycle grant latency, ack two cycles later ----
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    sb.push_back('{is_if: 1'b1, rdata: 32'h0000_0013});
    cyc();
    check1("fetch grant latency", mem_req, 1'b1);
    await_mem(32'h10, 1'b0, 3'b000, 32'h0, "fetch");
    hold_ack(2, 32'h0000_0013, 32'h10, 1'b0, 3'b000, 32'h0, "fetch");
    get_ready(1'b1, "fetch");

    // ---- simultaneous requests: data first, then fetch without re-request ----
    if_req  = 1'b1;
    if_addr = 32'h0000_0020;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0100;
    dm_type = 3'b010;
    sb.push_back('{is_if: 1'b0, rdata: 32'hA5A5_0001});
    sb.push_back('{is_if: 1'b1, rdata: 32'h0000_0093});
    cyc();
    await_mem(32'h100, 1'b0, 3'b010, 32'h0, "simul dm");
    hold_ack(1, 32'hA5A5_0001, 32'h100, 1'b0, 3'b010, 32'h0, "simul dm");
    get_ready(1'b1, "simul dm");
    await_mem(32'h20, 1'b0, 3'b000, 32'h0, "simul if");
    hold_ack(0, 32'h0000_0093, 32'h20, 1'b0, 3'b000, 32'h0, "simul if");
    get_ready(1'b1, "simul if");

    // ---- store: port holds the command, dm_rdata untouched ----
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0200;
    dm_wdata = 32'hDEAD_BEEF;
    dm_type  = 3'b010;
    sb.push_back('{is_if: 1'b0, rdata: 32'hA5A5_0001});
    cyc();
    await_mem(32'h200, 1'b1, 3'b010, 32'hDEAD_BEEF, "store");
    hold_ack(3, 32'h1234_5678, 32'h200, 1'b1, 3'b010, 32'hDEAD_BEEF, "store");
    get_ready(1'b1, "store");

    // ---- fairness: four data grants, then the fetch, with dm_req held ----
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_type = 3'b000;
    dm_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) sb.push_back('{is_if: 1'b0, rdata: 32'h100 + 32'(i)});
    sb.push_back('{is_if: 1'b1, rdata: 32'h0000_4444});
    sb.push_back('{is_if: 1'b0, rdata: 32'h0000_0105});
    for (int i = 0; i < 4; i++) begin
      await_mem(32'h300 + 32'(4 * i), 1'b0, 3'b000, 32'h0, "fair dm");
      hold_ack(0, 32'h100 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 3'b000, 32'h0, "fair dm");
      get_ready(1'b0, "fair dm");
      dm_addr = 32'h300 + 32'(4 * (i + 1));
    end
    await_mem(32'h40, 1'b0, 3'b000, 32'h0, "fair 5th grant if");
    hold_ack(1, 32'h0000_4444, 32'h40, 1'b0, 3'b000, 32'h0, "fair if");
    get_ready(1'b1, "fair if");
    await_mem(32'h310, 1'b0, 3'b000, 32'h0, "fair dm after if");
    hold_ack(0, 32'h0000_0105, 32'h310, 1'b0, 3'b000, 32'h0, "fair dm after if");
    get_ready(1'b1, "fair dm after if");

    // ---- timeout: no ack for 8 wait cycles ----
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0400;
    sb.push_back('{is_if: 1'b0, rdata: 32'h0000_0000});
    cyc();
    for (int i = 0; i < 8; i++) begin
      check1("timeout mem_req held", mem_req, 1'b1);
      if (i == 7) check1("timeout bus_err before", bus_err, 1'b0);
      cyc();
    end
    check1("timeout mem_req dropped", mem_req, 1'b0);
    check1("timeout bus_err set", bus_err, 1'b1);
    get_ready(1'b1, "timeout");

    // ---- arbitration continues, bus_err stays set ----
    if_req  = 1'b1;
    if_addr = 32'h0000_0084;
    sb.push_back('{is_if: 1'b1, rdata: 32'h0000_0077});
    cyc();
    await_mem(32'h84, 1'b0, 3'b000, 32'h0, "post-err fetch");
    hold_ack(1, 32'h0000_0077, 32'h84, 1'b0, 3'b000, 32'h0, "post-err fetch");
    get_ready(1'b1, "post-err fetch");
    check1("bus_err sticky", bus_err, 1'b1);

    // ---- reset in the middle of DM_WAIT ----
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0500;
    cyc();
    check1("midrst granted", mem_req, 1'b1);
    cyc();
    rst    = 1'b0;
    dm_req = 1'b0;
    #1;
    check1("midrst mem_req", mem_req, 1'b0);
    check1("midrst bus_err", bus_err, 1'b0);
    check1("midrst dm_ready", dm_ready, 1'b0);
    check("midrst if_rdata", if_rdata, 32'h0);
    check("midrst dm_rdata", dm_rdata, 32'h0);
    check("midrst mem_addr", mem_addr, 32'h0);
    cyc();
    rst = 1'b1;

    // A stray ack while idle must do nothing.
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0BAD;
    for (int i = 0; i < 5; i++) begin
      cyc();
      mem_ack = 1'b0;
      check1("post-rst no ready", if_ready | dm_ready, 1'b0);
      check1("post-rst idle", mem_req, 1'b0);
    end

    dm_req  = 1'b1;
    dm_addr = 32'h0000_0600;
    sb.push_back('{is_if: 1'b0, rdata: 32'h0000_0066});
    cyc();
    await_mem(32'h600, 1'b0, 3'b000, 32'h0, "post-rst dm");
    hold_ack(1, 32'h0000_0066, 32'h600, 1'b0, 3'b000, 32'h0, "post-rst dm");
    get_ready(1'b1, "post-rst dm");

    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
